// File: rtl/ce_lms_eq.sv
// Per-tone complex LMS equaliser with independent real/imag weights.
// A training phase updates on every sample, then tracking updates on pilots only.
//
// state    | meaning
// ST_TRAIN | forced training, weights adapt on every accepted sample
// ST_TRACK | tracking, weights adapt only on pilot samples
module ce_lms_eq #(
  parameter int DATA_W     = 40,
  parameter int FRAC_W     = 32,
  parameter int WEIGHT_W   = 34,
  parameter int NUM_TONES  = 2,
  parameter int TRAIN_SYMS = 4,
  localparam int TONE_W    = (NUM_TONES > 1) ? $clog2(NUM_TONES) : 1
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     in_valid,
  input  logic signed [DATA_W-1:0] in_real,
  input  logic signed [DATA_W-1:0] in_imag,
  input  logic                     in_pilot,
  input  logic                     in_sof,
  input  logic [3:0]               cfg_mu_shift,
  input  logic                     cfg_freeze,
  input  logic                     cfg_retrain,
  output logic                     out_valid,
  output logic signed [DATA_W-1:0] out_real,
  output logic signed [DATA_W-1:0] out_imag,
  output logic [TONE_W-1:0]        out_tone,
  output logic                     out_training
);

  localparam int TRAIN_TOTAL = TRAIN_SYMS * NUM_TONES;
  localparam int CNT_W       = $clog2(TRAIN_TOTAL + 1);
  localparam int PROD_W      = WEIGHT_W + DATA_W;
  localparam int E_W         = ((DATA_W > FRAC_W + 2) ? DATA_W : FRAC_W + 2) + 1;
  localparam int EX_W        = E_W + DATA_W;
  localparam int SUM_W       = ((EX_W > WEIGHT_W) ? EX_W : WEIGHT_W) + 1;

  localparam logic signed [WEIGHT_W-1:0] W_ONE = WEIGHT_W'(1) << FRAC_W;
  localparam logic signed [E_W-1:0]      E_ONE = E_W'(1) << FRAC_W;

  typedef enum logic {
    ST_TRAIN = 1'b0,
    ST_TRACK = 1'b1
  } state_t;

  function automatic logic signed [DATA_W-1:0] sat_data(input logic signed [PROD_W-1:0] v);
    logic [PROD_W-DATA_W:0] top;
    top = v[PROD_W-1:DATA_W-1];
    if ((&top) || (~|top)) return v[DATA_W-1:0];
    else if (v[PROD_W-1])  return {1'b1, {(DATA_W-1){1'b0}}};
    else                   return {1'b0, {(DATA_W-1){1'b1}}};
  endfunction

  function automatic logic signed [WEIGHT_W-1:0] sat_weight(input logic signed [SUM_W-1:0] v);
    logic [SUM_W-WEIGHT_W:0] top;
    top = v[SUM_W-1:WEIGHT_W-1];
    if ((&top) || (~|top)) return v[WEIGHT_W-1:0];
    else if (v[SUM_W-1])   return {1'b1, {(WEIGHT_W-1){1'b0}}};
    else                   return {1'b0, {(WEIGHT_W-1){1'b1}}};
  endfunction

  state_t state_q, state_d;

  logic [TONE_W-1:0] tone_cnt, tone_k, tone_next;
  logic [CNT_W-1:0]  train_cnt;
  logic              accept, do_update;

  // index 0 = real component, 1 = imag component
  logic signed [WEIGHT_W-1:0] w_q     [2][NUM_TONES];
  logic signed [DATA_W-1:0]   x       [2];
  logic signed [WEIGHT_W-1:0] w_sel   [2];
  logic signed [WEIGHT_W-1:0] w_new   [2];
  logic signed [PROD_W-1:0]   prod    [2];
  logic signed [PROD_W-1:0]   prod_sh [2];
  logic signed [DATA_W-1:0]   y       [2];
  logic signed [E_W-1:0]      err     [2];
  logic signed [EX_W-1:0]     ex      [2];
  logic signed [EX_W-1:0]     delta   [2];

  always_comb begin
    tone_k    = in_sof ? '0 : tone_cnt;
    tone_next = (tone_k == TONE_W'(NUM_TONES - 1)) ? '0 : tone_k + 1'b1;
    accept    = in_valid & ~cfg_retrain;
    do_update = accept & ~cfg_freeze & ((state_q == ST_TRAIN) | in_pilot);
  end

  // Update uses the saturated output of the same sample, so the error
  // reflects what was actually delivered downstream.
  always_comb begin
    x[0] = in_real;
    x[1] = in_imag;
    for (int c = 0; c < 2; c++) begin
      w_sel[c]   = w_q[c][tone_k];
      prod[c]    = PROD_W'(w_sel[c]) * PROD_W'(x[c]);
      prod_sh[c] = prod[c] >>> FRAC_W;
      y[c]       = sat_data(prod_sh[c]);
      err[c]     = E_ONE - E_W'(y[c]);
      ex[c]      = EX_W'(err[c]) * EX_W'(x[c]);
      delta[c]   = (ex[c] >>> FRAC_W) >>> cfg_mu_shift;
      w_new[c]   = sat_weight(SUM_W'(w_sel[c]) + SUM_W'(delta[c]));
    end
  end

  always_comb begin
    state_d      = state_q;
    out_training = (state_q == ST_TRAIN);
    case (state_q)
      ST_TRAIN: if (accept && (train_cnt == CNT_W'(TRAIN_TOTAL - 1))) state_d = ST_TRACK;
      ST_TRACK: state_d = ST_TRACK;
      default:  state_d = ST_TRAIN;
    endcase
    if (cfg_retrain) state_d = ST_TRAIN;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_TRAIN;
      tone_cnt  <= '0;
      train_cnt <= '0;
      out_valid <= 1'b0;
      out_real  <= '0;
      out_imag  <= '0;
      out_tone  <= '0;
    end else begin
      state_q   <= state_d;
      out_valid <= accept;
      if (cfg_retrain) begin
        tone_cnt  <= '0;
        train_cnt <= '0;
      end else if (accept) begin
        tone_cnt <= tone_next;
        if (state_q == ST_TRAIN) train_cnt <= train_cnt + 1'b1;
      end
      if (accept) begin
        out_real <= y[0];
        out_imag <= y[1];
        out_tone <= tone_k;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int c = 0; c < 2; c++)
        for (int t = 0; t < NUM_TONES; t++)
          w_q[c][t] <= W_ONE;
    end else if (cfg_retrain) begin
      for (int c = 0; c < 2; c++)
        for (int t = 0; t < NUM_TONES; t++)
          w_q[c][t] <= W_ONE;
    end else if (do_update) begin
      for (int c = 0; c < 2; c++)
        w_q[c][tone_k] <= w_new[c];
    end
  end

endmodule

// File: tb/tb_ce_lms_eq.sv
// Directed bench for ce_lms_eq at default parameters; weights are observed by
// sending a frozen sample of 1.0, whose output equals the stored weight.
module tb_ce_lms_eq;

  localparam logic [39:0] X_HALF = 40'h0080000000;
  localparam logic [39:0] X_QTR  = 40'h0040000000;
  localparam logic [39:0] X_ONE  = 40'h0100000000;
  localparam logic [39:0] X_PMAX = 40'h7FFFFFFFFF;
  localparam logic [39:0] X_NMAX = 40'h8000000001;
  localparam logic [39:0] X_NMIN = 40'h8000000000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               reset_n, in_valid, in_pilot, in_sof, cfg_freeze, cfg_retrain;
  logic signed [39:0] in_real, in_imag, out_real, out_imag;
  logic [3:0]         cfg_mu_shift;
  logic               out_valid, out_training;
  logic [0:0]         out_tone;

  int checks = 0;
  int errors = 0;

  ce_lms_eq dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_real(in_real), .in_imag(in_imag),
    .in_pilot(in_pilot), .in_sof(in_sof), .cfg_mu_shift(cfg_mu_shift), .cfg_freeze(cfg_freeze),
    .cfg_retrain(cfg_retrain), .out_valid(out_valid), .out_real(out_real), .out_imag(out_imag),
    .out_tone(out_tone), .out_training(out_training)
  );

  task automatic drive(input logic v, input logic [39:0] r, input logic [39:0] i,
                       input logic pilot, input logic sof);
    in_valid = v; in_real = r; in_imag = i; in_pilot = pilot; in_sof = sof;
    @(posedge clk); #1;
  endtask

  task automatic retrain();
    cfg_retrain = 1'b1;
    drive(1'b0, '0, '0, 1'b0, 1'b0);
    cfg_retrain = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; in_valid = 0; in_real = '0; in_imag = '0; in_pilot = 0; in_sof = 0;
    cfg_mu_shift = 4'd0; cfg_freeze = 0; cfg_retrain = 0;
    #22;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got %b exp 0", out_valid); end
    checks++; if (out_real !== 40'h0) begin errors++; $display("FAIL rst_real got %h exp 0", out_real); end
    checks++; if (out_imag !== 40'h0) begin errors++; $display("FAIL rst_imag got %h exp 0", out_imag); end
    checks++; if (out_tone !== 1'b0) begin errors++; $display("FAIL rst_tone got %b exp 0", out_tone); end
    checks++; if (out_training !== 1'b1) begin errors++; $display("FAIL rst_training got %b exp 1", out_training); end
    @(negedge clk); reset_n = 1'b1;
    cfg_freeze = 1'b1;
    drive(1'b1, X_ONE, X_ONE, 1'b0, 1'b0);
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL first_valid got %b exp 1", out_valid); end
    checks++; if (out_real !== X_ONE) begin errors++; $display("FAIL rst_wr got %h exp %h", out_real, X_ONE); end
    checks++; if (out_imag !== X_ONE) begin errors++; $display("FAIL rst_wi got %h exp %h", out_imag, X_ONE); end
    cfg_freeze = 1'b0;
  endtask

  task automatic test_passthrough();
    retrain();
    cfg_freeze = 1'b1;
    drive(1'b1, X_HALF, X_HALF, 1'b0, 1'b1);
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL pass_valid got %b exp 1", out_valid); end
    checks++; if (out_real !== X_HALF) begin errors++; $display("FAIL pass_real got %h exp %h", out_real, X_HALF); end
    checks++; if (out_imag !== X_HALF) begin errors++; $display("FAIL pass_imag got %h exp %h", out_imag, X_HALF); end
    drive(1'b0, '0, '0, 1'b0, 1'b0);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL idle_valid got %b exp 0", out_valid); end
    drive(1'b1, X_ONE, X_ONE, 1'b0, 1'b1);
    checks++; if (out_real !== X_ONE) begin errors++; $display("FAIL pass_wr got %h exp %h", out_real, X_ONE); end
    checks++; if (out_imag !== X_ONE) begin errors++; $display("FAIL pass_wi got %h exp %h", out_imag, X_ONE); end
    cfg_freeze = 1'b0;
  endtask

  task automatic test_training();
    retrain();
    cfg_mu_shift = 4'd0;
    drive(1'b1, X_HALF, '0, 1'b0, 1'b1);
    checks++; if (out_real !== X_HALF) begin errors++; $display("FAIL train1_real got %h exp %h", out_real, X_HALF); end
    checks++; if (out_imag !== 40'h0) begin errors++; $display("FAIL train1_imag got %h exp 0", out_imag); end
    drive(1'b1, X_HALF, '0, 1'b0, 1'b1);
    checks++; if (out_real !== 40'h00A0000000) begin errors++; $display("FAIL train2_real got %h exp 00a0000000", out_real); end
    cfg_freeze = 1'b1;
    drive(1'b1, X_ONE, X_ONE, 1'b0, 1'b1);
    checks++; if (out_real !== 40'h0170000000) begin errors++; $display("FAIL train_wr got %h exp 0170000000", out_real); end
    checks++; if (out_imag !== X_ONE) begin errors++; $display("FAIL train_wi got %h exp %h", out_imag, X_ONE); end
    drive(1'b1, X_ONE, X_ONE, 1'b0, 1'b0);
    checks++; if (out_tone !== 1'b1) begin errors++; $display("FAIL train_tone1 got %b exp 1", out_tone); end
    checks++; if (out_real !== X_ONE) begin errors++; $display("FAIL train_w1 got %h exp %h", out_real, X_ONE); end
    cfg_freeze = 1'b0;
    retrain();
    cfg_mu_shift = 4'd1;
    drive(1'b1, X_HALF, X_QTR, 1'b0, 1'b1);
    checks++; if (out_imag !== X_QTR) begin errors++; $display("FAIL mu_imag got %h exp %h", out_imag, X_QTR); end
    cfg_freeze = 1'b1;
    drive(1'b1, X_ONE, X_ONE, 1'b0, 1'b1);
    checks++; if (out_real !== 40'h0120000000) begin errors++; $display("FAIL mu_wr got %h exp 0120000000", out_real); end
    checks++; if (out_imag !== 40'h0118000000) begin errors++; $display("FAIL mu_wi got %h exp 0118000000", out_imag); end
    cfg_freeze = 1'b0;
    cfg_mu_shift = 4'd0;
  endtask

  task automatic test_train_track();
    retrain();
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, '0, '0, 1'b0, (i % 2) == 0);
      checks++;
      if (out_training !== (i < 7)) begin
        errors++; $display("FAIL track_training[%0d] got %b exp %b", i, out_training, (i < 7));
      end
    end
    drive(1'b1, X_HALF, '0, 1'b0, 1'b1);
    checks++; if (out_real !== X_HALF) begin errors++; $display("FAIL track_np_real got %h exp %h", out_real, X_HALF); end
    cfg_freeze = 1'b1;
    drive(1'b1, X_ONE, X_ONE, 1'b0, 1'b1);
    checks++; if (out_real !== X_ONE) begin errors++; $display("FAIL track_np_w got %h exp %h", out_real, X_ONE); end
    cfg_freeze = 1'b0;
    drive(1'b1, X_HALF, '0, 1'b1, 1'b1);
    cfg_freeze = 1'b1;
    drive(1'b1, X_ONE, X_ONE, 1'b0, 1'b1);
    checks++; if (out_real !== 40'h0140000000) begin errors++; $display("FAIL track_pilot_w got %h exp 0140000000", out_real); end
    retrain();
    for (int i = 0; i < 8; i++) drive(1'b1, X_HALF, X_HALF, 1'b0, (i % 2) == 0);
    checks++; if (out_training !== 1'b0) begin errors++; $display("FAIL frz_count got %b exp 0", out_training); end
    cfg_freeze = 1'b0;
  endtask

  task automatic test_saturation();
    logic [39:0] exp_r [4];
    logic [39:0] exp_i [4];
    exp_r = '{X_NMAX, X_PMAX, X_NMIN, X_PMAX};
    exp_i = '{X_PMAX, X_NMIN, X_PMAX, X_NMIN};
    retrain();
    cfg_mu_shift = 4'd0;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, X_NMAX, X_PMAX, 1'b1, 1'b1);
      checks++;
      if (out_real !== exp_r[i]) begin errors++; $display("FAIL sat_real[%0d] got %h exp %h", i, out_real, exp_r[i]); end
      checks++;
      if (out_imag !== exp_i[i]) begin errors++; $display("FAIL sat_imag[%0d] got %h exp %h", i, out_imag, exp_i[i]); end
    end
    cfg_freeze = 1'b1;
    drive(1'b1, X_ONE, X_ONE, 1'b0, 1'b1);
    checks++; if (out_real !== 40'h01FFFFFFFF) begin errors++; $display("FAIL sat_wr got %h exp 01ffffffff", out_real); end
    checks++; if (out_imag !== 40'h01FFFFFFFF) begin errors++; $display("FAIL sat_wi got %h exp 01ffffffff", out_imag); end
    cfg_freeze = 1'b0;
  endtask

  task automatic test_sof();
    retrain();
    cfg_mu_shift = 4'd0;
    drive(1'b1, '0, '0, 1'b0, 1'b1);
    drive(1'b1, X_HALF, '0, 1'b0, 1'b1);
    checks++; if (out_tone !== 1'b0) begin errors++; $display("FAIL sof_tone got %b exp 0", out_tone); end
    checks++; if (out_real !== X_HALF) begin errors++; $display("FAIL sof_real got %h exp %h", out_real, X_HALF); end
    cfg_freeze = 1'b1;
    drive(1'b1, X_ONE, X_ONE, 1'b0, 1'b0);
    checks++; if (out_tone !== 1'b1) begin errors++; $display("FAIL sof_next_tone got %b exp 1", out_tone); end
    checks++; if (out_real !== X_ONE) begin errors++; $display("FAIL sof_w1 got %h exp %h", out_real, X_ONE); end
    drive(1'b1, X_ONE, X_ONE, 1'b0, 1'b1);
    checks++; if (out_real !== 40'h0140000000) begin errors++; $display("FAIL sof_w0 got %h exp 0140000000", out_real); end
    cfg_freeze = 1'b0;
  endtask

  task automatic test_retrain_reset();
    cfg_freeze = 1'b1;
    for (int i = 0; i < 4; i++) drive(1'b1, '0, '0, 1'b0, (i % 2) == 0);
    checks++; if (out_training !== 1'b0) begin errors++; $display("FAIL pre_rt_training got %b exp 0", out_training); end
    cfg_freeze = 1'b0;
    cfg_retrain = 1'b1;
    drive(1'b1, X_HALF, X_HALF, 1'b0, 1'b1);
    cfg_retrain = 1'b0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rt_valid got %b exp 0", out_valid); end
    checks++; if (out_training !== 1'b1) begin errors++; $display("FAIL rt_training got %b exp 1", out_training); end
    cfg_freeze = 1'b1;
    drive(1'b1, X_ONE, X_ONE, 1'b0, 1'b1);
    checks++; if (out_real !== X_ONE) begin errors++; $display("FAIL rt_wr got %h exp %h", out_real, X_ONE); end
    cfg_freeze = 1'b0;
    drive(1'b1, X_HALF, '0, 1'b0, 1'b1);
    #3 reset_n = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL arst_valid got %b exp 0", out_valid); end
    checks++; if (out_real !== 40'h0) begin errors++; $display("FAIL arst_real got %h exp 0", out_real); end
    checks++; if (out_training !== 1'b1) begin errors++; $display("FAIL arst_training got %b exp 1", out_training); end
    @(negedge clk); reset_n = 1'b1;
    cfg_freeze = 1'b1;
    drive(1'b1, X_ONE, X_ONE, 1'b0, 1'b0);
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL arst_first got %b exp 1", out_valid); end
    checks++; if (out_tone !== 1'b0) begin errors++; $display("FAIL arst_tone got %b exp 0", out_tone); end
    checks++; if (out_real !== X_ONE) begin errors++; $display("FAIL arst_wr got %h exp %h", out_real, X_ONE); end
    cfg_freeze = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout got running exp finished");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_passthrough();
    test_training();
    test_train_track();
    test_saturation();
    test_sof();
    test_retrain_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
